// File: rtl/dest_pipe_hazard_if.sv
// Bundle of the EX/ID-side inputs and the pipelined destination / hazard-control
// outputs exchanged between the core datapath and the destination pipe + hazard unit.
interface dest_pipe_hazard_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] writeregE;
  logic             regwriteE;
  logic             memtoregE;
  logic [REG_W-1:0] rsD;
  logic [REG_W-1:0] rtD;
  logic [REG_W-1:0] rsE;
  logic [REG_W-1:0] rtE;
  logic             branchD;
  logic             stallM;
  logic             flushM;
  logic [REG_W-1:0] writeregM;
  logic [REG_W-1:0] writeregW;
  logic             regwriteM;
  logic             regwriteW;
  logic             memtoregM;
  logic             memtoregW;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             forwardAD;
  logic             forwardBD;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             flushE;

  // Datapath side: supplies pipeline state, consumes forward/stall controls.
  modport master (
    output writeregE, regwriteE, memtoregE, rsD, rtD, rsE, rtE, branchD, stallM, flushM,
    input  writeregM, writeregW, regwriteM, regwriteW, memtoregM, memtoregW,
    input  forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, flushE
  );

  // Hazard unit side.
  modport slave (
    input  writeregE, regwriteE, memtoregE, rsD, rtD, rsE, rtE, branchD, stallM, flushM,
    output writeregM, writeregW, regwriteM, regwriteW, memtoregM, memtoregW,
    output forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, flushE
  );
endinterface

// File: rtl/dest_pipe_hazard.sv
// Carries the EX destination/write-enable/load flag through EX/MEM and MEM/WB and
// derives forwarding selects plus load-use / branch stall and flush controls.
module dest_pipe_hazard #(
  parameter int REG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  dest_pipe_hazard_if.slave  bus
);
  logic [REG_W-1:0] writereg_m_reg;
  logic [REG_W-1:0] writereg_w_reg;
  logic             regwrite_m_reg;
  logic             regwrite_w_reg;
  logic             memtoreg_m_reg;
  logic             memtoreg_w_reg;

  // While MEM is stalled, WB receives a bubble so the held instruction retires once.
  always_ff @(posedge clk) begin
    if (rst) begin
      writereg_m_reg <= '0;
      regwrite_m_reg <= 1'b0;
      memtoreg_m_reg <= 1'b0;
      writereg_w_reg <= '0;
      regwrite_w_reg <= 1'b0;
      memtoreg_w_reg <= 1'b0;
    end else begin
      if (bus.flushM) begin
        writereg_m_reg <= '0;
        regwrite_m_reg <= 1'b0;
        memtoreg_m_reg <= 1'b0;
      end else if (!bus.stallM) begin
        writereg_m_reg <= bus.writeregE;
        regwrite_m_reg <= bus.regwriteE;
        memtoreg_m_reg <= bus.memtoregE;
      end
      if (bus.stallM) begin
        writereg_w_reg <= '0;
        regwrite_w_reg <= 1'b0;
        memtoreg_w_reg <= 1'b0;
      end else begin
        writereg_w_reg <= writereg_m_reg;
        regwrite_w_reg <= regwrite_m_reg;
        memtoreg_w_reg <= memtoreg_m_reg;
      end
    end
  end

  assign bus.writeregM = writereg_m_reg;
  assign bus.regwriteM = regwrite_m_reg;
  assign bus.memtoregM = memtoreg_m_reg;
  assign bus.writeregW = writereg_w_reg;
  assign bus.regwriteW = regwrite_w_reg;
  assign bus.memtoregW = memtoreg_w_reg;

  logic [1:0][REG_W-1:0] src_e;
  logic [1:0][REG_W-1:0] src_d;
  logic [1:0][1:0]       fwd_e;
  logic [1:0]            fwd_d;

  assign src_e[0] = bus.rsE;
  assign src_e[1] = bus.rtE;
  assign src_d[0] = bus.rsD;
  assign src_d[1] = bus.rtD;

  // Operand 0 is rs, operand 1 is rt; register $0 never matches.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_m;
      logic hit_w;
      assign hit_m = (src_e[gi] != '0) && regwrite_m_reg && (src_e[gi] == writereg_m_reg);
      assign hit_w = (src_e[gi] != '0) && regwrite_w_reg && (src_e[gi] == writereg_w_reg);
      assign fwd_e[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
      assign fwd_d[gi] = (src_d[gi] != '0) && regwrite_m_reg && (src_d[gi] == writereg_m_reg);
    end
  endgenerate

  assign bus.forwardAE = fwd_e[0];
  assign bus.forwardBE = fwd_e[1];
  assign bus.forwardAD = fwd_d[0];
  assign bus.forwardBD = fwd_d[1];

  logic e_hits_d;
  logic m_hits_d;
  logic lwstall;
  logic branchstall;

  assign e_hits_d = (bus.writeregE != '0) &&
                    ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));
  assign m_hits_d = (writereg_m_reg != '0) &&
                    ((writereg_m_reg == bus.rsD) || (writereg_m_reg == bus.rtD));

  assign lwstall     = bus.memtoregE && bus.regwriteE && e_hits_d;
  assign branchstall = bus.branchD && ((bus.regwriteE && e_hits_d) || (memtoreg_m_reg && m_hits_d));

  // A MEM stall freezes ID/EX, so the bubble insertion is suppressed then.
  assign bus.stallF = lwstall || branchstall || bus.stallM;
  assign bus.stallD = lwstall || branchstall || bus.stallM;
  assign bus.stallE = bus.stallM;
  assign bus.flushE = (lwstall || branchstall) && !bus.stallM;
endmodule

// File: tb/tb_dest_pipe_hazard.sv
// Directed scenarios plus randomized traffic against a behavioural stage model.
module tb_dest_pipe_hazard;
  logic clk;
  logic rst;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0] dest;
    logic       wr;
    logic       ld;
  } stage_t;

  stage_t mdl_m = '0;
  stage_t mdl_w = '0;

  dest_pipe_hazard_if #(.REG_W(5)) bus ();
  dest_pipe_hazard #(.REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic hits(logic [4:0] r, stage_t s);
    return (r != 5'd0) && s.wr && (s.dest == r);
  endfunction

  function automatic logic [1:0] fwd_sel(logic [4:0] r);
    if (hits(r, mdl_m)) return 2'b10;
    if (hits(r, mdl_w)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stage_t e_stage();
    return '{dest: bus.writeregE, wr: bus.regwriteE, ld: bus.memtoregE};
  endfunction

  function automatic logic [9:0] exp_hazard();
    stage_t e;
    logic lw, br, st;
    e  = e_stage();
    lw = e.ld && (hits(bus.rsD, e) || hits(bus.rtD, e));
    br = bus.branchD && (hits(bus.rsD, e) || hits(bus.rtD, e) ||
         (mdl_m.ld && mdl_m.dest != 5'd0 && (mdl_m.dest == bus.rsD || mdl_m.dest == bus.rtD)));
    st = lw || br || bus.stallM;
    return {fwd_sel(bus.rsE), fwd_sel(bus.rtE), hits(bus.rsD, mdl_m), hits(bus.rtD, mdl_m),
            st, st, bus.stallM, (lw || br) && !bus.stallM};
  endfunction

  task automatic set_idle();
    rst = 1'b0;
    bus.writeregE = '0; bus.regwriteE = 1'b0; bus.memtoregE = 1'b0;
    bus.rsD = '0; bus.rtD = '0; bus.rsE = '0; bus.rtE = '0;
    bus.branchD = 1'b0; bus.stallM = 1'b0; bus.flushM = 1'b0;
  endtask

  task automatic set_e(logic [4:0] d, logic wr, logic ld);
    bus.writeregE = d; bus.regwriteE = wr; bus.memtoregE = ld;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic cycle();
    stage_t nm, nw;
    if (rst) begin
      nm = '0; nw = '0;
    end else begin
      nm = bus.flushM ? stage_t'('0) : (bus.stallM ? mdl_m : e_stage());
      nw = bus.stallM ? stage_t'('0) : mdl_m;
    end
    @(posedge clk);
    #1;
    mdl_m = nm;
    mdl_w = nw;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    set_e(5'd13, 1'b1, 1'b1);
    cycle();
    cycle();
    set_idle();
    #1;
    checks++;
    if ({bus.writeregM, bus.regwriteM, bus.memtoregM, bus.writeregW, bus.regwriteW, bus.memtoregW} !== 14'd0) begin
      failures++;
      $display("FAIL reset_regs actual=%h required=0", {bus.writeregM, bus.regwriteM, bus.memtoregM, bus.writeregW, bus.regwriteW, bus.memtoregW});
    end
    checks++;
    if ({bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.forwardBD, bus.stallF, bus.stallD, bus.stallE, bus.flushE} !== 10'd0) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=0", {bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.forwardBD, bus.stallF, bus.stallD, bus.stallE, bus.flushE});
    end
    $display("txn reset done");
  endtask

  task automatic test_latency();
    set_idle();
    set_e(5'd8, 1'b1, 1'b0);
    cycle();
    set_idle();
    #1;
    checks++;
    if ({bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW} !== {5'd8, 1'b1, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL latency_edge1 actual=M%0d/%0b W%0d/%0b required=M8/1 W0/0", bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW);
    end
    cycle();
    checks++;
    if ({bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW} !== {5'd0, 1'b0, 5'd8, 1'b1}) begin
      failures++;
      $display("FAIL latency_edge2 actual=M%0d/%0b W%0d/%0b required=M0/0 W8/1", bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW);
    end
    $display("txn latency done");
  endtask

  task automatic test_forward_priority();
    set_idle();
    set_e(5'd9, 1'b1, 1'b0);
    cycle();
    cycle();
    set_idle();
    bus.rsE = 5'd9; bus.rtE = 5'd10;
    #1;
    checks++;
    if ({bus.forwardAE, bus.forwardBE} !== 4'b1000) begin
      failures++;
      $display("FAIL fwd_m_wins actual=%b_%b required=10_00", bus.forwardAE, bus.forwardBE);
    end
    bus.flushM = 1'b1;
    cycle();
    bus.flushM = 1'b0;
    #1;
    checks++;
    if (bus.forwardAE !== 2'b01) begin
      failures++;
      $display("FAIL fwd_w_after_flush actual=%b required=01", bus.forwardAE);
    end
    $display("txn forward_priority done");
  endtask

  task automatic test_load_use();
    set_idle();
    cycle(); cycle();
    set_e(5'd4, 1'b1, 1'b1);
    bus.rtD = 5'd4;
    #1;
    checks++;
    if ({bus.stallF, bus.stallD, bus.flushE, bus.stallE} !== 4'b1110) begin
      failures++;
      $display("FAIL load_use_stall actual=%b required=1110", {bus.stallF, bus.stallD, bus.flushE, bus.stallE});
    end
    cycle();
    set_idle();
    bus.rtE = 5'd4;
    #1;
    checks++;
    if ({bus.stallF, bus.flushE, bus.forwardBE} !== 4'b0010) begin
      failures++;
      $display("FAIL load_use_fwd actual=%b required=0010", {bus.stallF, bus.flushE, bus.forwardBE});
    end
    $display("txn load_use done");
  endtask

  task automatic test_branch();
    set_idle();
    cycle(); cycle();
    bus.branchD = 1'b1; bus.rsD = 5'd5;
    set_e(5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if ({bus.stallF, bus.flushE} !== 2'b11) begin
      failures++;
      $display("FAIL branch_alu_stall actual=%b required=11", {bus.stallF, bus.flushE});
    end
    cycle();
    set_e(5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({bus.stallF, bus.forwardAD} !== 2'b01) begin
      failures++;
      $display("FAIL branch_alu_release actual=%b required=01", {bus.stallF, bus.forwardAD});
    end
    set_e(5'd5, 1'b1, 1'b1);
    cycle();
    set_e(5'd5, 1'b1, 1'b1);
    #1;
    checks++;
    if (bus.stallD !== 1'b1) begin
      failures++;
      $display("FAIL branch_load_stall1 actual=%b required=1", bus.stallD);
    end
    cycle();
    set_e(5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stallD !== 1'b1) begin
      failures++;
      $display("FAIL branch_load_stall2 actual=%b required=1", bus.stallD);
    end
    set_idle();
    set_e(5'd6, 1'b1, 1'b0);
    cycle();
    set_idle();
    bus.rtD = 5'd6;
    #1;
    checks++;
    if ({bus.forwardBD, bus.forwardAD, bus.stallF} !== 3'b100) begin
      failures++;
      $display("FAIL branch_fwd_bd actual=%b required=100", {bus.forwardBD, bus.forwardAD, bus.stallF});
    end
    $display("txn branch done");
  endtask

  task automatic test_stall_mem();
    set_idle();
    set_e(5'd7, 1'b1, 1'b0);
    cycle();
    bus.stallM = 1'b1;
    set_e(5'd3, 1'b1, 1'b1);
    bus.rsD = 5'd3;
    #1;
    checks++;
    if ({bus.stallE, bus.flushE, bus.stallF} !== 3'b101) begin
      failures++;
      $display("FAIL stallm_ctrl actual=%b required=101", {bus.stallE, bus.flushE, bus.stallF});
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW} !== {5'd7, 1'b1, 5'd0, 1'b0}) begin
        failures++;
        $display("FAIL stallm_hold%0d actual=M%0d/%0b W%0d/%0b required=M7/1 W0/0", i, bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW);
      end
    end
    set_idle();
    cycle();
    checks++;
    if ({bus.writeregW, bus.regwriteW} !== {5'd7, 1'b1}) begin
      failures++;
      $display("FAIL stallm_release actual=W%0d/%0b required=W7/1", bus.writeregW, bus.regwriteW);
    end
    cycle();
    checks++;
    if ({bus.writeregW, bus.regwriteW} !== {5'd0, 1'b0}) begin
      failures++;
      $display("FAIL stallm_once actual=W%0d/%0b required=W0/0", bus.writeregW, bus.regwriteW);
    end
    $display("txn stall_mem done");
  endtask

  task automatic test_zero_corners();
    set_idle();
    set_e(5'd0, 1'b1, 1'b1);
    bus.branchD = 1'b1;
    #1;
    checks++;
    if ({bus.stallF, bus.flushE} !== 2'b00) begin
      failures++;
      $display("FAIL zero_no_stall actual=%b required=00", {bus.stallF, bus.flushE});
    end
    cycle();
    set_e(5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.stallD} !== 6'b0) begin
      failures++;
      $display("FAIL zero_no_fwd actual=%b required=000000", {bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.stallD});
    end
    set_idle();
    set_e(5'd7, 1'b1, 1'b0);
    cycle();
    bus.flushM = 1'b1; bus.stallM = 1'b1;
    cycle();
    checks++;
    if ({bus.writeregM, bus.regwriteM, bus.memtoregM} !== 7'd0) begin
      failures++;
      $display("FAIL flush_over_stall actual=M%0d/%0b required=M0/0", bus.writeregM, bus.regwriteM);
    end
    set_idle();
    set_e(5'd7, 1'b1, 1'b1);
    cycle();
    cycle();
    bus.stallM = 1'b1;
    rst = 1'b1;
    cycle();
    set_idle();
    #1;
    checks++;
    if ({bus.writeregM, bus.regwriteM, bus.memtoregM, bus.writeregW, bus.regwriteW, bus.memtoregW} !== 14'd0) begin
      failures++;
      $display("FAIL rst_in_stall actual=%h required=0", {bus.writeregM, bus.regwriteM, bus.memtoregM, bus.writeregW, bus.regwriteW, bus.memtoregW});
    end
    $display("txn zero_corners done");
  endtask

  task automatic test_random();
    logic [13:0] exp_regs;
    logic [9:0]  exp_ctrl;
    logic [4:0]  d;
    for (int n = 0; n < 200; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.regwriteE = $urandom_range(0, 3) != 0;
      d = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      bus.writeregE = bus.regwriteE ? d : 5'd0;
      bus.memtoregE = bus.regwriteE && ($urandom_range(0, 2) == 0);
      bus.rsD = 5'($urandom_range(0, 3));
      bus.rtD = 5'($urandom_range(0, 3));
      bus.rsE = 5'($urandom_range(0, 3));
      bus.rtE = 5'($urandom_range(0, 3));
      bus.branchD = $urandom_range(0, 2) == 0;
      bus.stallM = $urandom_range(0, 4) == 0;
      bus.flushM = $urandom_range(0, 7) == 0;
      #1;
      exp_regs = {mdl_m, mdl_w};
      exp_ctrl = exp_hazard();
      checks++;
      if ({bus.writeregM, bus.regwriteM, bus.memtoregM, bus.writeregW, bus.regwriteW, bus.memtoregW} !== exp_regs) begin
        failures++;
        $display("FAIL rand_regs n=%0d actual=%h required=%h", n, {bus.writeregM, bus.regwriteM, bus.memtoregM, bus.writeregW, bus.regwriteW, bus.memtoregW}, exp_regs);
      end
      checks++;
      if ({bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.forwardBD, bus.stallF, bus.stallD, bus.stallE, bus.flushE} !== exp_ctrl) begin
        failures++;
        $display("FAIL rand_ctrl n=%0d actual=%b required=%b", n, {bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.forwardBD, bus.stallF, bus.stallD, bus.stallE, bus.flushE}, exp_ctrl);
      end
      $display("txn rand %0d rst=%0b stM=%0b flM=%0b M=%0d/%0b W=%0d/%0b ctrl=%b", n, rst, bus.stallM, bus.flushM, mdl_m.dest, mdl_m.wr, mdl_w.dest, mdl_w.wr, exp_ctrl);
      cycle();
    end
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_latency();
    test_forward_priority();
    test_load_use();
    test_branch();
    test_stall_mem();
    test_zero_corners();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
